// File: rtl/decoder_sweep_pkg.sv
// Shared types and defaults for the register-file write-select decoder.
package decoder_pkg;

  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/decoder_sweep_onehot_dec.sv
// Combinational ADDR_W -> 2**ADDR_W one-hot decoder with enable.
module onehot_dec #(
  parameter  int ADDR_W = 3,
  localparam int OUTS   = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  output logic [OUTS-1:0]   o_onehot
);

  // Single bit set at i_addr when enabled, all-zero otherwise.
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_addr] = 1'b1;
  end

endmodule

// File: rtl/decoder_sweep.sv
// Registered write-select decoder with a hardware clear sweep.
// Optional feature macro: DECODER_ZERO_REG_EN makes index OUTS-1 a
// hardwired-zero register (never selected, skipped by the sweep).
//
// state | meaning
// IDLE  | decode we_i/addr_i, accept sweep_start_i
// SWEEP | drive 1<<idx each cycle, writes dropped
// DONE  | one-cycle completion pulse, writes serviced, start ignored
module decoder_sweep
  import decoder_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int OUTS   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic              sweep_start_i,
  output logic [OUTS-1:0]   decoded_o,
  output logic              sweep_busy_o,
  output logic              sweep_done_o,
  output logic [ADDR_W-1:0] sweep_idx_o,
  output logic              write_drop_o
);

`ifdef DECODER_ZERO_REG_EN
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUTS - 2);
`else
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUTS - 1);
`endif

  sweep_state_t      r_state;
  sweep_state_t      w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [OUTS-1:0]   r_decoded;
  logic              r_drop;

  logic              w_start_acc;
  logic              w_last;
  logic              w_sweep_next;
  logic [ADDR_W-1:0] w_idx_next;
  logic              w_zero_hit;
  logic              w_we_acc;
  logic              w_drop_next;
  logic [ADDR_W-1:0] w_dec_addr;
  logic              w_dec_en;
  logic [OUTS-1:0]   w_dec_onehot;

`ifdef DECODER_ZERO_REG_EN
  assign w_zero_hit = (addr_i == ADDR_W'(OUTS - 1));
`else
  assign w_zero_hit = 1'b0;
`endif

  assign w_start_acc = (r_state == IDLE) && sweep_start_i;
  assign w_last      = (r_idx == LAST_IDX);

  // Sweep control and write acceptance for the coming edge.
  always_comb begin
    w_sweep_next = 1'b0;
    w_idx_next   = '0;
    if (w_start_acc) begin
      w_sweep_next = 1'b1;
      w_idx_next   = '0;
    end else if ((r_state == SWEEP) && !w_last) begin
      w_sweep_next = 1'b1;
      w_idx_next   = r_idx + 1'b1;
    end
    // Start wins over a coincident write; writes during the sweep are lost.
    w_we_acc    = we_i && !w_zero_hit &&
                  (((r_state == IDLE) && !sweep_start_i) || (r_state == DONE));
    w_drop_next = we_i && ((r_state == SWEEP) || w_start_acc);
  end

  assign w_dec_addr = w_sweep_next ? w_idx_next : addr_i;
  assign w_dec_en   = w_sweep_next | w_we_acc;

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
    .i_addr   (w_dec_addr),
    .i_en     (w_dec_en),
    .o_onehot (w_dec_onehot)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (sweep_start_i) w_state_next = SWEEP;
      SWEEP:   if (w_last)        w_state_next = DONE;
      DONE:                       w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    sweep_busy_o = 1'b0;
    sweep_done_o = 1'b0;
    sweep_idx_o  = '0;
    case (r_state)
      SWEEP: begin
        sweep_busy_o = 1'b1;
        sweep_idx_o  = r_idx;
      end
      DONE:    sweep_done_o = 1'b1;
      default: ;
    endcase
  end

  // Registered select, sweep index and drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_decoded <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_idx     <= w_idx_next;
      r_decoded <= w_dec_onehot;
      r_drop    <= w_drop_next;
    end
  end

  assign decoded_o    = r_decoded;
  assign write_drop_o = r_drop;

endmodule

// File: tb/tb_decoder_sweep.sv
// Directed self-checking bench for decoder_sweep (ADDR_W = 3).
module tb_decoder_sweep;

  localparam int ADDR_W = 3;
  localparam int OUTS   = 1 << ADDR_W;
`ifdef DECODER_ZERO_REG_EN
  localparam int LAST = OUTS - 2;
`else
  localparam int LAST = OUTS - 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] addr_i;
  logic              we_i;
  logic              sweep_start_i;
  logic [OUTS-1:0]   decoded_o;
  logic              sweep_busy_o;
  logic              sweep_done_o;
  logic [ADDR_W-1:0] sweep_idx_o;
  logic              write_drop_o;

  int errors = 0;
  int checks = 0;

  decoder_sweep #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .addr_i        (addr_i),
    .we_i          (we_i),
    .sweep_start_i (sweep_start_i),
    .decoded_o     (decoded_o),
    .sweep_busy_o  (sweep_busy_o),
    .sweep_done_o  (sweep_done_o),
    .sweep_idx_o   (sweep_idx_o),
    .write_drop_o  (write_drop_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [OUTS-1:0] dec, input logic busy,
                           input logic done, input logic [ADDR_W-1:0] idx, input logic drop);
    check({tag, ".decoded"}, 32'(decoded_o), 32'(dec));
    check({tag, ".busy"},    32'(sweep_busy_o), 32'(busy));
    check({tag, ".done"},    32'(sweep_done_o), 32'(done));
    check({tag, ".idx"},     32'(sweep_idx_o), 32'(idx));
    check({tag, ".drop"},    32'(write_drop_o), 32'(drop));
  endtask

  task automatic check_sweep_step(input string tag, input int i, input logic drop);
    logic [OUTS-1:0] one;
    one = OUTS'(1) << i;
    check_all($sformatf("%s_i%0d", tag, i), one, 1'b1, 1'b0, ADDR_W'(i), drop);
  endtask

  initial begin
    logic [OUTS-1:0] exp_dec;
    reset = 1'b1; addr_i = '0; we_i = 1'b0; sweep_start_i = 1'b0;
    #2;
    check_all("reset", '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    reset = 1'b0;

    // Plain writes to every index, one per cycle.
    for (int a = 0; a < OUTS; a++) begin
      we_i = 1'b1; addr_i = ADDR_W'(a);
      tick();
      exp_dec = OUTS'(1) << a;
`ifdef DECODER_ZERO_REG_EN
      if (a == OUTS - 1) exp_dec = '0;
`endif
      check_all($sformatf("write%0d", a), exp_dec, 1'b0, 1'b0, '0, 1'b0);
    end
    we_i = 1'b0; addr_i = 3'd6;
    tick();
    check_all("we0", '0, 1'b0, 1'b0, '0, 1'b0);

    // Sweep 1: write coincident with start, write at cycle 2, start during sweep.
    sweep_start_i = 1'b1; we_i = 1'b1; addr_i = 3'd3;
    tick();
    check_sweep_step("sw1", 0, 1'b1);
    sweep_start_i = 1'b0; we_i = 1'b0;
    tick();
    check_sweep_step("sw1", 1, 1'b0);
    we_i = 1'b1; addr_i = 3'd3;
    tick();
    check_sweep_step("sw1", 2, 1'b1);
    we_i = 1'b0;
    tick();
    check_sweep_step("sw1", 3, 1'b0);
    sweep_start_i = 1'b1;
    tick();
    check_sweep_step("sw1", 4, 1'b0);
    sweep_start_i = 1'b0;
    for (int i = 5; i <= LAST; i++) begin
      tick();
      check_sweep_step("sw1", i, 1'b0);
    end
    tick();
    check_all("sw1_done", '0, 1'b0, 1'b1, '0, 1'b0);

    // Start in DONE is ignored; a write in DONE is serviced.
    sweep_start_i = 1'b1; we_i = 1'b1; addr_i = 3'd2;
    tick();
    check_all("done_wr", 8'h04, 1'b0, 1'b0, '0, 1'b0);

    // Start one cycle after DONE begins a fresh full sweep.
    we_i = 1'b0;
    tick();
    check_sweep_step("sw2", 0, 1'b0);
    sweep_start_i = 1'b0;
    for (int i = 1; i <= LAST; i++) begin
      tick();
      check_sweep_step("sw2", i, 1'b0);
    end
    tick();
    check_all("sw2_done", '0, 1'b0, 1'b1, '0, 1'b0);
    tick();
    check_all("sw2_idle", '0, 1'b0, 1'b0, '0, 1'b0);

    // Sweep 3: asynchronous reset at cycle 4.
    sweep_start_i = 1'b1;
    tick();
    check_sweep_step("sw3", 0, 1'b0);
    sweep_start_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_sweep_step("sw3", i, 1'b0);
    end
    #1 reset = 1'b1;
    #1;
    check_all("rst_mid", '0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    reset = 1'b0;
    we_i = 1'b1; addr_i = 3'd5;
    tick();
    check_all("post_rst_wr5", 8'h20, 1'b0, 1'b0, '0, 1'b0);
    we_i = 1'b0;
    tick();
    check_all("post_rst_idle", '0, 1'b0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
